// File: rtl/vfpu_issue.sv
// Issue/collect controller in front of the vfpu: credit-limited operand issue plus an in-order result FIFO.
// Optional stall statistic built only when VFPU_ISSUE_STATS_EN is defined.
module vfpu_issue #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [1:0]            op_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [DATA_WIDTH-1:0] vfpu_operandA_o,
  output logic [DATA_WIDTH-1:0] vfpu_operandB_o,
  output logic                  vfpu_valid_o,
  output logic [1:0]            vfpu_op_o,
  input  logic                  vfpu_ready_i,
  input  logic                  vfpu_done_i,
  input  logic [DATA_WIDTH-1:0] vfpu_result_i,
  output logic                  ovf_err_o,
  output logic [31:0]           stall_cycles_o,
  output logic [1:0]            dbg_state_o
);

  // Streams: a transfer happens in a cycle where valid and ready are both high at the
  // rising edge; A and B share one ready, so the pair is always consumed together.

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic [LEN_WIDTH-1:0]  retired_q;
  logic [1:0]            op_q;
  logic [CW-1:0]         credit_q, credit_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] opa_q;
  logic [DATA_WIDTH-1:0] opb_q;
  logic                  valid_q;
  logic                  ovf_q;
  logic                  zero_done_q;

  logic start_ok;
  logic fire;
  logic fifo_full;
  logic fifo_empty;
  logic accept_done;
  logic push;
  logic drop;
  logic pop;
  logic done_pulse;

  assign start_ok    = (state_q == S_IDLE) && start_i;
  assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign fire        = (state_q == S_RUN) && a_valid_i && b_valid_i && vfpu_ready_i &&
                       (credit_q != '0) && (issued_q != len_q);
  assign accept_done = vfpu_done_i && (state_q != S_IDLE);
  assign push        = accept_done && !fifo_full;
  assign drop        = accept_done && fifo_full;
  assign pop         = !fifo_empty && r_ready_i;

  always_comb begin
    state_d    = state_q;
    done_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && (len_i != '0)) state_d = S_RUN;
      end
      S_RUN: begin
        if (fire && ((issued_q + LEN_WIDTH'(1)) == len_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((retired_q == len_q) && fifo_empty && !pop) begin
          state_d    = S_IDLE;
          done_pulse = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Credits return on pop, not on retire: a slot is only free once the result has left.
  always_comb begin
    credit_d = credit_q;
    case ({pop, fire})
      2'b10:   credit_d = credit_q + CW'(1);
      2'b01:   credit_d = credit_q - CW'(1);
      default: credit_d = credit_q;
    endcase
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      retired_q   <= '0;
      op_q        <= '0;
      ovf_q       <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= start_ok && (len_i == '0);
      if (start_ok) begin
        len_q     <= len_i;
        op_q      <= op_i;
        issued_q  <= '0;
        retired_q <= '0;
        ovf_q     <= 1'b0;
      end else begin
        if (fire)        issued_q  <= issued_q + LEN_WIDTH'(1);
        if (accept_done) retired_q <= retired_q + LEN_WIDTH'(1);
        if (drop)        ovf_q     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      valid_q <= fire;
      if (fire) begin
        opa_q <= a_data_i;
        opb_q <= b_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= CW'(FIFO_DEPTH);
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      credit_q <= credit_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= vfpu_result_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

`ifdef VFPU_ISSUE_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state_q == S_RUN) && a_valid_i && b_valid_i && (credit_q == '0) &&
                 (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

  assign a_ready_o       = fire;
  assign b_ready_o       = fire;
  assign vfpu_valid_o    = valid_q;
  assign vfpu_operandA_o = opa_q;
  assign vfpu_operandB_o = opb_q;
  assign vfpu_op_o       = op_q;
  assign r_valid_o       = !fifo_empty;
  assign r_data_o        = mem_q[rd_ptr_q];
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = done_pulse || zero_done_q;
  assign ovf_err_o       = ovf_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_vfpu_issue.sv
// Bench for vfpu_issue: randomized operand streams, a fixed-latency vfpu stand-in,
// and an in-order scoreboard of expected results.
module tb_vfpu_issue;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = 16;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [LW-1:0] len_i;
  logic [1:0]    op_i;
  logic          busy_o, done_o;
  logic          a_valid_i, a_ready_o, b_valid_i, b_ready_o;
  logic [DW-1:0] a_data_i, b_data_i;
  logic          r_valid_o, r_ready_i;
  logic [DW-1:0] r_data_o;
  logic [DW-1:0] vfpu_operandA_o, vfpu_operandB_o;
  logic          vfpu_valid_o;
  logic [1:0]    vfpu_op_o;
  logic          vfpu_ready_i;
  logic          vfpu_done_i;
  logic [DW-1:0] vfpu_result_i;
  logic          ovf_err_o;
  logic [31:0]   stall_cycles_o;
  logic [1:0]    dbg_state_o;

  logic [DW-1:0] exp_q[$];
  int            n_pass  = 0;
  int            n_total = 0;
  logic [1:0]    cur_op  = '0;
  int            issue_cnt = 0;

  always #5 clk = ~clk;

  vfpu_issue #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i), .op_i(op_i),
    .busy_o(busy_o), .done_o(done_o),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_data_i(b_data_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
    .vfpu_operandA_o(vfpu_operandA_o), .vfpu_operandB_o(vfpu_operandB_o),
    .vfpu_valid_o(vfpu_valid_o), .vfpu_op_o(vfpu_op_o), .vfpu_ready_i(vfpu_ready_i),
    .vfpu_done_i(vfpu_done_i), .vfpu_result_i(vfpu_result_i),
    .ovf_err_o(ovf_err_o), .stall_cycles_o(stall_cycles_o), .dbg_state_o(dbg_state_o)
  );

  // Stand-in arithmetic for the datapath; the controller only moves and orders words.
  function automatic logic [DW-1:0] ref_op(input logic [1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // vfpu model: fixed three-cycle pipeline, cleared by the shared reset
  logic          pv0, pv1, pv2;
  logic [DW-1:0] pr0, pr1, pr2;
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      pv0 <= 1'b0; pv1 <= 1'b0; pv2 <= 1'b0;
      pr0 <= '0;   pr1 <= '0;   pr2 <= '0;
    end else begin
      pv0 <= vfpu_valid_o;
      pr0 <= ref_op(vfpu_op_o, vfpu_operandA_o, vfpu_operandB_o);
      pv1 <= pv0; pr1 <= pr0;
      pv2 <= pv1; pr2 <= pr1;
    end
  end
  assign vfpu_done_i   = pv2;
  assign vfpu_result_i = pr2;

  // Monitor: every result handshake pops the oldest expected value
  always @(negedge clk) begin
    if (rst_ni) begin
      if (r_valid_o && r_ready_i) begin
        if (exp_q.size() == 0) check("r_unexpected", 64'd1, 64'd0);
        else check("r_data", r_data_o, exp_q.pop_front());
      end
      if (vfpu_valid_o) begin
        issue_cnt++;
        check("vfpu_op", vfpu_op_o, cur_op);
      end
    end
  end

  // mode 0: streams always valid, r_ready 1 after hold; 1: everything random;
  // 2: B idle for the first 10 cycles, then always valid
  task automatic run_job(input int len, input logic [1:0] op, input int mode, input int rr_hold,
                         input int budget, input bit need_done,
                         output int fires, output int dones, output int first_done,
                         output int hold_fires);
    logic [DW-1:0] cur_a, cur_b;
    int after_done;
    cur_a = $urandom; cur_b = $urandom;
    fires = 0; dones = 0; first_done = -1; hold_fires = -1; after_done = 0;
    cur_op = op;
    @(posedge clk); #1;
    start_i = 1'b1; len_i = LW'(len); op_i = op;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      start_i = (mode == 0) && (len > 2) && (cyc == 1);
      case (mode)
        1: begin
          a_valid_i    = ($urandom_range(0, 3) != 0);
          b_valid_i    = ($urandom_range(0, 3) != 0);
          vfpu_ready_i = ($urandom_range(0, 3) != 0);
        end
        2: begin
          a_valid_i = 1'b1; b_valid_i = (cyc >= 10); vfpu_ready_i = 1'b1;
        end
        default: begin
          a_valid_i = 1'b1; b_valid_i = 1'b1; vfpu_ready_i = 1'b1;
        end
      endcase
      r_ready_i = (cyc < rr_hold) ? 1'b0 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
      a_data_i  = cur_a;
      b_data_i  = cur_b;
      @(negedge clk);
      check("ab_ready_joint", a_ready_o, b_ready_o);
      if (a_ready_o) begin
        check("fire_needs_valid", a_valid_i & b_valid_i & vfpu_ready_i, 1'b1);
        exp_q.push_back(ref_op(op, cur_a, cur_b));
        fires++;
        cur_a = $urandom; cur_b = $urandom;
      end
      if (mode == 2 && cyc < 10) begin
        check("a_ready_while_b_idle", a_ready_o, 1'b0);
        check("vfpu_valid_while_b_idle", vfpu_valid_o, 1'b0);
      end
      if (rr_hold > 0 && cyc == rr_hold - 1) hold_fires = fires;
      if (done_o) begin
        if (dones == 0) first_done = cyc;
        dones++;
      end
      @(posedge clk); #1;
      if (dones > 0) after_done++;
      if (need_done && after_done == 5) break;
    end
    start_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0;
  endtask

  int fires, dones, first_done, hold_fires;

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; len_i = '0; op_i = '0;
    a_valid_i = 1'b1; b_valid_i = 1'b1; vfpu_ready_i = 1'b1; r_ready_i = 1'b1;
    a_data_i = '0; b_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_a_ready", a_ready_o, 1'b0);
    check("rst_b_ready", b_ready_o, 1'b0);
    check("rst_r_valid", r_valid_o, 1'b0);
    check("rst_vfpu_valid", vfpu_valid_o, 1'b0);
    check("rst_opA", vfpu_operandA_o, '0);
    check("rst_opB", vfpu_operandB_o, '0);
    check("rst_op", vfpu_op_o, '0);
    check("rst_ovf", ovf_err_o, 1'b0);
    check("rst_stall", stall_cycles_o, '0);
    @(posedge clk); #1;
    rst_ni = 1'b1; a_valid_i = 1'b0; b_valid_i = 1'b0;

    // zero-length job
    issue_cnt = 0;
    run_job(0, OP_MUL, 0, 0, 20, 1'b1, fires, dones, first_done, hold_fires);
    check("len0_fires", fires, 0);
    check("len0_issues", issue_cnt, 0);
    check("len0_dones", dones, 1);
    check("len0_done_cycle", first_done, 0);

    // short MUL job with ignored mid-job start
    issue_cnt = 0;
    run_job(4, OP_MUL, 0, 0, 200, 1'b1, fires, dones, first_done, hold_fires);
    check("len4_fires", fires, 4);
    check("len4_issues", issue_cnt, 4);
    check("len4_dones", dones, 1);
    check("len4_drained", exp_q.size(), 0);
    check("len4_busy_end", busy_o, 1'b0);
    check("len4_ovf", ovf_err_o, 1'b0);

    // backpressure: credits must cap issue at the FIFO depth
    run_job(20, OP_ADD, 0, 50, 400, 1'b1, fires, dones, first_done, hold_fires);
    check("bp_issue_cap", hold_fires, DEPTH);
    check("bp_fires", fires, 20);
    check("bp_dones", dones, 1);
    check("bp_drained", exp_q.size(), 0);
    check("bp_ovf", ovf_err_o, 1'b0);
`ifdef VFPU_ISSUE_STATS_EN
    check("bp_stall_nonzero", stall_cycles_o != 0, 1'b1);
`else
    check("bp_stall_tied", stall_cycles_o, '0);
`endif

    // B lagging behind A
    run_job(6, OP_SUB, 2, 0, 200, 1'b1, fires, dones, first_done, hold_fires);
    check("blag_fires", fires, 6);
    check("blag_dones", dones, 1);
    check("blag_drained", exp_q.size(), 0);

    // random jobs
    for (int j = 0; j < 6; j++) begin
      int len;
      len = $urandom_range(1, 30);
      run_job(len, 2'($urandom_range(0, 2)), 1, $urandom_range(0, 20), 2000, 1'b1,
              fires, dones, first_done, hold_fires);
      check("rnd_fires", fires, len);
      check("rnd_dones", dones, 1);
      check("rnd_drained", exp_q.size(), 0);
      check("rnd_ovf", ovf_err_o, 1'b0);
    end

    // reset while draining with three results queued
    run_job(3, OP_ADD, 0, 1000, 20, 1'b0, fires, dones, first_done, hold_fires);
    check("drain_fires", fires, 3);
    @(negedge clk);
    check("drain_busy", busy_o, 1'b1);
    check("drain_r_valid", r_valid_o, 1'b1);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(negedge clk);
    check("mid_rst_r_valid", r_valid_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_ni = 1'b1;
    run_job(1, OP_ADD, 0, 0, 100, 1'b1, fires, dones, first_done, hold_fires);
    check("post_rst_fires", fires, 1);
    check("post_rst_dones", dones, 1);
    check("post_rst_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
